uart_loader: RTL and testbench
==============================

UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 24_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning UART bit rate.
REQ-003 SHALL have parameter ADDR_WIDTH, default 14, meaning main-memory word-address width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rx  input  1  asynchronous UART receive line, idle high.
REQ-007 SHALL have port mem_write  output  1  one-cycle word write strobe to main memory.
REQ-008 SHALL have port mem_wmask  output  4  byte enables, 4'b1111 whenever mem_write=1, else 0.
REQ-009 SHALL have port mem_addr  output  ADDR_WIDTH  word address of the current write.
REQ-010 SHALL have port mem_wdata  output  32  assembled little-endian data word.
REQ-011 SHALL have port cpu_rst  output  1  holds the pipeline in reset until load completes.
REQ-012 SHALL have ports busy, done, error  output  1 each  loader status flags.

Function
REQ-013 SHALL pass rx through a 2-flop synchroniser, preset to 1, before any use.
REQ-014 SHALL use CLKS_PER_BIT = CLOCK_RATE/BAUD_RATE (integer division; 208 at defaults).
REQ-015 SHALL detect a start bit on a synchronised falling edge, re-check low at CLKS_PER_BIT/2, else return to idle without a byte.
REQ-016 SHALL sample 8 data bits LSB-first at bit centres, then the stop bit; stop=0 is a framing error.
REQ-017 SHALL emit each received byte as an internal one-cycle byte_valid pulse in the cycle after the stop-bit sample.
REQ-018 SHALL implement frame-FSM states HUNT, LEN0, LEN1, DATA, CSUM, DONE, ERROR.
REQ-019 HUNT: byte 8'hA5 -> LEN0; any other byte is discarded, stay HUNT.
REQ-020 LEN0/LEN1: capture word count N[7:0] then N[15:8]; after LEN1, N=0 -> DONE (or CSUM when checksum enabled), else DATA.
REQ-021 DATA: bytes fill mem_wdata little-endian (first byte into [7:0]); on the 4th byte, assert mem_write for exactly one cycle the next cycle at the current mem_addr.
REQ-022 mem_addr SHALL start at 0 per frame and increment by 1 after each write, wrapping modulo 2^ADDR_WIDTH when N exceeds 2^ADDR_WIDTH.
REQ-023 After the N-th write, FSM SHALL go to CSUM (checksum enabled) or DONE.
REQ-024 A framing error in any state other than DONE SHALL force ERROR; no further mem_write until reset.
REQ-025 busy=1 in LEN0, LEN1, DATA, CSUM; done=1 only in DONE; error=1 only in ERROR.
REQ-026 cpu_rst SHALL be 1 in every state except DONE; it falls in the cycle DONE is entered and stays 0.
REQ-027 DONE and ERROR SHALL be terminal; rx activity there SHALL be ignored.

Reset
REQ-028 rst=1 SHALL return FSM to HUNT and the UART receiver to idle, discarding any partial byte or frame.
REQ-029 During and after reset: mem_write=0, mem_wmask=0, mem_addr=0, mem_wdata=0, cpu_rst=1, busy=0, done=0, error=0.
REQ-030 Reset asserted mid-frame SHALL take effect on the next clock edge, overriding any write scheduled for that cycle.

Configuration
REQ-031 With macro UART_LOADER_CHECKSUM_EN defined, the running XOR of all DATA bytes (init 8'h00) SHALL be compared to the byte received in CSUM: match -> DONE, mismatch -> ERROR.
REQ-032 Without UART_LOADER_CHECKSUM_EN, state CSUM and the XOR register SHALL be absent; the FSM goes straight to DONE.

Verification
REQ-033 Bytes 00,A5,01,00,78,56,34,12[,csum 08] -> one mem_write, addr 0, wdata 32'h12345678, wmask F; then done=1, cpu_rst=0.
REQ-034 Frame with N=2 and data 11..18 -> writes 32'h14131211 at addr 0 and 32'h18171615 at addr 1, mem_write pulses exactly 2 cycles in total.
REQ-035 Byte with stop bit driven 0 during DATA -> error=1, cpu_rst stays 1, no further mem_write.
REQ-036 Checksum enabled, frame N=1 with data 01,02,03,04 and csum 05 -> error=1; with csum 04 -> done=1.
REQ-037 Glitch on rx low for 50 clk while idle -> no byte is received and the FSM stays in HUNT.
REQ-038 rst pulsed 1 cycle after 2 DATA bytes, then a full N=1 frame -> single write at addr 0 containing only new-frame data.

Source files
------------

// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_loader
// Description : UART boot loader. Receives framed bytes (A5, N[7:0], N[15:8],
//               4*N data bytes little-endian) and writes N words to main
//               memory from address 0, holding the CPU in reset until done.
//               Optional macro UART_LOADER_CHECKSUM_EN appends an XOR
//               checksum byte that must match before the CPU is released.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_loader #(
  parameter int CLOCK_RATE = 24_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  mem_write,
  output logic [3:0]            mem_wmask,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int c_CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int c_CNT_W        = $clog2(c_CLKS_PER_BIT + 1);
  localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(c_CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'((c_CLKS_PER_BIT / 2) - 1);

  // Receiver states
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Frame states; bits [4:2] are {error, done, busy} so the status outputs
  // come straight from state flops with no decode logic behind them.
  typedef enum logic [4:0] {
    HUNT  = 5'b000_00,
    LEN0  = 5'b001_00,
    LEN1  = 5'b001_01,
    DATA  = 5'b001_10,
`ifdef UART_LOADER_CHECKSUM_EN
    CSUM  = 5'b001_11,
`endif
    DONE  = 5'b010_00,
    ERROR = 5'b100_00
  } frame_state_t;

  logic               r_rx_meta;
  logic               r_rx_sync;
  logic               r_rx_prev;
  rx_state_t          r_rx_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_byte_valid;
  logic               r_frame_err;

  frame_state_t          r_state;
  logic [15:0]           r_words_left;
  logic [1:0]            r_byte_idx;
  logic                  r_mem_write;
  logic [3:0]            r_mem_wmask;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  // Two-flop synchroniser plus one delay flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // UART byte receiver: start re-check at half bit, then sample at bit centres
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state   <= RX_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'h00;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_cnt <= '0;
          if (r_rx_prev && !r_rx_sync) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (r_cnt == c_HALF_LAST) begin
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            // A line that is high again at mid-start was only a glitch
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_cnt == c_BIT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_sync, r_shift[7:1]};
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
            else                   r_bit_idx  <= r_bit_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (r_cnt == c_BIT_LAST) begin
            r_cnt        <= '0;
            r_rx_state   <= RX_IDLE;
            r_byte_valid <= r_rx_sync;
            r_frame_err  <= ~r_rx_sync;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Frame parser and memory write sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= HUNT;
      r_words_left <= 16'd0;
      r_byte_idx   <= 2'd0;
      r_mem_write  <= 1'b0;
      r_mem_wmask  <= 4'h0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'h0;
`ifdef UART_LOADER_CHECKSUM_EN
      r_csum       <= 8'h00;
`endif
    end else begin
      r_mem_write <= 1'b0;
      r_mem_wmask <= 4'h0;
      if (r_frame_err && (r_state != DONE) && (r_state != ERROR)) begin
        r_state <= ERROR;
      end else begin
        case (r_state)
          HUNT: begin
            if (r_byte_valid && (r_shift == 8'hA5)) begin
              r_state    <= LEN0;
              r_mem_addr <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
              r_csum     <= 8'h00;
`endif
            end
          end
          LEN0: begin
            if (r_byte_valid) begin
              r_words_left[7:0] <= r_shift;
              r_state           <= LEN1;
            end
          end
          LEN1: begin
            if (r_byte_valid) begin
              r_words_left[15:8] <= r_shift;
              r_byte_idx         <= 2'd0;
              if ({r_shift, r_words_left[7:0]} != 16'd0) r_state <= DATA;
`ifdef UART_LOADER_CHECKSUM_EN
              else                                       r_state <= CSUM;
`else
              else                                       r_state <= DONE;
`endif
            end
          end
          DATA: begin
            if (r_byte_valid) begin
              r_mem_wdata[{r_byte_idx, 3'b000} +: 8] <= r_shift;
              r_byte_idx <= r_byte_idx + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
              r_csum     <= r_csum ^ r_shift;
`endif
              if (r_byte_idx == 2'd3) begin
                r_mem_write <= 1'b1;
                r_mem_wmask <= 4'hF;
              end
            end
            // Advance address and word count once the write has been issued
            if (r_mem_write) begin
              r_mem_addr   <= r_mem_addr + ADDR_WIDTH'(1);
              r_words_left <= r_words_left - 16'd1;
              if (r_words_left == 16'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
                r_state <= CSUM;
`else
                r_state <= DONE;
`endif
              end
            end
          end
`ifdef UART_LOADER_CHECKSUM_EN
          CSUM: begin
            if (r_byte_valid) r_state <= (r_shift == r_csum) ? DONE : ERROR;
          end
`endif
          DONE:    ;
          ERROR:   ;
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign mem_write = r_mem_write;
  assign mem_wmask = r_mem_wmask;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_state[2];
  assign done      = r_state[3];
  assign error     = r_state[4];
  assign cpu_rst   = ~r_state[3];

endmodule
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_loader
// Description : Directed self-checking bench for uart_loader. Runs the
//               receiver at 110 clocks per bit so a 50-clock glitch stays
//               shorter than half a bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_loader;

  localparam int CPB = 110;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;

  uart_loader #(
    .CLOCK_RATE(11_000_000),
    .BAUD_RATE (100_000),
    .ADDR_WIDTH(14)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .mem_write(mem_write),
    .mem_wmask(mem_wmask),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Write monitor: logs every cycle mem_write is high and counts pulses
  int          wr_cnt   = 0;
  int          pulses   = 0;
  int          mask_bad = 0;
  logic        prev_mw  = 1'b0;
  logic [13:0] log_addr [64];
  logic [31:0] log_data [64];
  logic [3:0]  log_mask [64];

  always @(negedge clk) begin
    if (mem_write) begin
      log_addr[wr_cnt % 64] = mem_addr;
      log_data[wr_cnt % 64] = mem_wdata;
      log_mask[wr_cnt % 64] = mem_wmask;
      wr_cnt = wr_cnt + 1;
      if (!prev_mw) pulses = pulses + 1;
    end else if (mem_wmask != 4'h0) begin
      mask_bad = mask_bad + 1;
    end
    prev_mw = mem_write;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b1);
  endtask

  task automatic do_reset();
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  int base;
  int pbase;

  initial begin
    rx  = 1'b1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_wmask",     {28'd0, mem_wmask}, 32'd0);
    check("rst_addr",      {18'd0, mem_addr},  32'd0);
    check("rst_wdata",     mem_wdata,          32'd0);
    check("rst_cpu_rst",   {31'd0, cpu_rst},   32'd1);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_done",      {31'd0, done},      32'd0);
    check("rst_error",     {31'd0, error},     32'd0);
    @(posedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // 50-clock low glitch while idle: no byte, stay in HUNT
    base = wr_cnt;
    rx = 1'b0;
    repeat (50) @(posedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    check("glitch_busy",  {31'd0, busy},  32'd0);
    check("glitch_error", {31'd0, error}, 32'd0);
    check("glitch_done",  {31'd0, done},  32'd0);

    // Single-word frame
    send(8'hA5);
    @(negedge clk);
    check("len0_busy",    {31'd0, busy},    32'd1);
    check("len0_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    send(8'h01); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
`ifdef UART_LOADER_CHECKSUM_EN
    send(8'h08);
`endif
    @(negedge clk);
    check("f1_writes",  wr_cnt - base,        32'd1);
    check("f1_addr",    {18'd0, log_addr[base % 64]}, 32'd0);
    check("f1_data",    log_data[base % 64],  32'h12345678);
    check("f1_mask",    {28'd0, log_mask[base % 64]}, 32'hF);
    check("f1_done",    {31'd0, done},        32'd1);
    check("f1_cpu_rst", {31'd0, cpu_rst},     32'd0);
    check("f1_busy",    {31'd0, busy},        32'd0);

    // DONE is terminal: new frame and a framing error are ignored
    send(8'hA5);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    check("done_hold",       {31'd0, done},  32'd1);
    check("done_no_error",   {31'd0, error}, 32'd0);
    check("done_no_writes",  wr_cnt - base,  32'd1);

    // Two-word frame with a leading junk byte
    do_reset();
    base  = wr_cnt;
    pbase = pulses;
    send(8'h00);
    send(8'hA5); send(8'h02); send(8'h00);
    for (int i = 0; i < 8; i++) send(8'h11 + 8'(i));
`ifdef UART_LOADER_CHECKSUM_EN
    send(8'h08);
`endif
    @(negedge clk);
    check("f2_write_cycles", wr_cnt - base,   32'd2);
    check("f2_pulses",       pulses - pbase,  32'd2);
    check("f2_addr0", {18'd0, log_addr[base % 64]},       32'd0);
    check("f2_data0", log_data[base % 64],                32'h14131211);
    check("f2_addr1", {18'd0, log_addr[(base + 1) % 64]}, 32'd1);
    check("f2_data1", log_data[(base + 1) % 64],          32'h18171615);
    check("f2_done",  {31'd0, done},                      32'd1);

    // Framing error during DATA
    do_reset();
    base = wr_cnt;
    send(8'hA5); send(8'h01); send(8'h00); send(8'h01);
    send_byte(8'h02, 1'b0);
    @(negedge clk);
    check("ferr_error",   {31'd0, error},   32'd1);
    check("ferr_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("ferr_busy",    {31'd0, busy},    32'd0);
    check("ferr_done",    {31'd0, done},    32'd0);
    send(8'h03); send(8'h04); send(8'h05); send(8'h06);
    @(negedge clk);
    check("ferr_no_writes", wr_cnt - base,  32'd0);
    check("ferr_hold",      {31'd0, error}, 32'd1);

    // Reset mid-frame, then a clean single-word frame
    do_reset();
    base = wr_cnt;
    send(8'hA5); send(8'h02); send(8'h00); send(8'hAA); send(8'hBB);
    @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy",  {31'd0, busy}, 32'd0);
    check("mid_rst_wdata", mem_wdata,     32'd0);
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
`ifdef UART_LOADER_CHECKSUM_EN
    send(8'h04);
`endif
    @(negedge clk);
    check("mid_rst_writes", wr_cnt - base,               32'd1);
    check("mid_rst_addr",   {18'd0, log_addr[base % 64]}, 32'd0);
    check("mid_rst_data",   log_data[base % 64],         32'h04030201);
    check("mid_rst_done",   {31'd0, done},               32'd1);

`ifdef UART_LOADER_CHECKSUM_EN
    // Checksum mismatch
    do_reset();
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05);
    @(negedge clk);
    check("csum_bad_error",   {31'd0, error},   32'd1);
    check("csum_bad_done",    {31'd0, done},    32'd0);
    check("csum_bad_cpu_rst", {31'd0, cpu_rst}, 32'd1);
`endif

    check("wmask_idle_zero", mask_bad, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
